// File: rtl/rotate_kick_engine_if.sv
// Request/result and collision-checker handshake bundle for rotate_kick_engine.
// master drives requests and checker responses; slave is the engine itself.
interface rotate_kick_engine_if #(
   parameter int unsigned XW = 5,
   parameter int unsigned YW = 6
);
   logic          start;
   logic [1:0]    dir;
   logic [2:0]    piece;
   logic [1:0]    rot_in;
   logic [XW-1:0] x_in;
   logic [YW-1:0] y_in;
   logic          chk_req;
   logic [1:0]    chk_rot;
   logic [XW-1:0] chk_x;
   logic [YW-1:0] chk_y;
   logic          chk_ack;
   logic          chk_hit;
   logic          busy;
   logic          done;
   logic          success;
   logic [1:0]    rot_out;
   logic [XW-1:0] x_out;
   logic [YW-1:0] y_out;
   logic [2:0]    kick_idx;

   modport master (
      output start, dir, piece, rot_in, x_in, y_in, chk_ack, chk_hit,
      input  chk_req, chk_rot, chk_x, chk_y, busy, done, success, rot_out, x_out, y_out,
             kick_idx
   );

   modport slave (
      input  start, dir, piece, rot_in, x_in, y_in, chk_ack, chk_hit,
      output chk_req, chk_rot, chk_x, chk_y, busy, done, success, rot_out, x_out, y_out,
             kick_idx
   );
endinterface

// File: rtl/rotate_kick_engine.sv
// Sequential SRS rotation resolver: probes up to N_KICKS wall-kick candidates through an
// external collision checker. Define ROT180_EN to add 180-degree rotation (dir=10).
module rotate_kick_engine #(
   parameter int unsigned N_KICKS = 5,
   parameter int unsigned XW      = 5,
   parameter int unsigned YW      = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   rotate_kick_engine_if.slave  bus
);
   typedef enum logic [2:0] {StIdle, StCalc, StProbe, StNext, StFin} state_e;

   localparam logic [2:0] LastK = 3'(N_KICKS - 1);

   // Returns {x[2:0], y[2:0]} y-up offset for a piece, rotation state and test index.
   function automatic logic [5:0] srs_off(input logic [2:0] pc, input logic [1:0] r,
                                          input logic [2:0] k);
      logic [2:0] ox;
      logic [2:0] oy;
      ox = 3'd0;
      oy = 3'd0;
      if (pc == 3'd0) begin
         unique case (r)
            2'd0: begin
               if (k == 3'd1 || k == 3'd3) ox = 3'b111;
               else if (k == 3'd2 || k == 3'd4) ox = 3'd2;
            end
            2'd1: begin
               if (k == 3'd0) ox = 3'b111;
               if (k == 3'd3) oy = 3'd1;
               else if (k == 3'd4) oy = 3'b110;
            end
            2'd2: begin
               if (k == 3'd0) ox = 3'b111;
               else if (k == 3'd1 || k == 3'd3) ox = 3'd1;
               else ox = 3'b110;
               oy = (k <= 3'd2) ? 3'd1 : 3'd0;
            end
            2'd3: begin
               if (k <= 3'd2) oy = 3'd1;
               else if (k == 3'd3) oy = 3'b111;
               else oy = 3'd2;
            end
         endcase
      end else if (pc != 3'd1 && pc != 3'd7) begin
         if (r[0]) begin
            if (k != 3'd0 && k != 3'd3) ox = r[1] ? 3'b111 : 3'd1;
            if (k == 3'd2) oy = 3'b111;
            else if (k >= 3'd3) oy = 3'd2;
         end
      end
      return {ox, oy};
   endfunction

   state_e        state_q, state_d;
   logic [2:0]    k_q, k_d;
   logic [1:0]    from_q, from_d;
   logic [1:0]    to_q, to_d;
   logic [2:0]    piece_q, piece_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [XW-1:0] cx_q, cx_d;
   logic [YW-1:0] cy_q, cy_d;
   logic          succ_q, succ_d;
   logic [1:0]    rout_q, rout_d;
   logic [XW-1:0] xout_q, xout_d;
   logic [YW-1:0] yout_q, yout_d;
   logic [2:0]    kidx_q, kidx_d;
   logic          rsv_q, rsv_d;
`ifdef ROT180_EN
   logic          half_q, half_d;
`endif

   logic              dir_ok;
   logic [1:0]        to_rot;
   logic [5:0]        off_f, off_t;
   logic signed [3:0] kx, ky;

`ifdef ROT180_EN
   assign dir_ok = (bus.dir != 2'b11);
`else
   assign dir_ok = ~bus.dir[1];
`endif

   always_comb begin
      to_rot = bus.dir[0] ? bus.rot_in - 2'd1 : bus.rot_in + 2'd1;
`ifdef ROT180_EN
      if (bus.dir[1]) to_rot = bus.rot_in + 2'd2;
`endif
   end

   always_comb begin
      off_f = srs_off(piece_q, from_q, k_q);
      off_t = srs_off(piece_q, to_q, k_q);
      kx = $signed({off_f[5], off_f[5:3]}) - $signed({off_t[5], off_t[5:3]});
      ky = $signed({off_f[2], off_f[2:0]}) - $signed({off_t[2], off_t[2:0]});
`ifdef ROT180_EN
      // 180 turns use a fixed kick list instead of offset differences.
      if (half_q) begin
         kx = 4'sd0;
         ky = 4'sd0;
         case (k_q)
            3'd1:    ky = 4'sd1;
            3'd2:    kx = 4'sd1;
            3'd3:    kx = -4'sd1;
            3'd4:    ky = -4'sd1;
            default: ;
         endcase
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      from_d  = from_q;
      to_d    = to_q;
      piece_d = piece_q;
      x_d     = x_q;
      y_d     = y_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      succ_d  = succ_q;
      rout_d  = rout_q;
      xout_d  = xout_q;
      yout_d  = yout_q;
      kidx_d  = kidx_q;
      rsv_d   = 1'b0;
`ifdef ROT180_EN
      half_d  = half_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               if (dir_ok) begin
                  from_d  = bus.rot_in;
                  to_d    = to_rot;
                  piece_d = bus.piece;
                  x_d     = bus.x_in;
                  y_d     = bus.y_in;
                  k_d     = 3'd0;
                  state_d = StCalc;
`ifdef ROT180_EN
                  half_d  = bus.dir[1];
`endif
               end else begin
                  rsv_d  = 1'b1;
                  succ_d = 1'b0;
                  rout_d = bus.rot_in;
                  xout_d = bus.x_in;
                  yout_d = bus.y_in;
                  kidx_d = 3'd0;
               end
            end
         end
         StCalc: begin
            // y_in grows downward while kicks are y-up, hence the subtraction.
            cx_d    = x_q + XW'(kx);
            cy_d    = y_q - YW'(ky);
            state_d = StProbe;
         end
         StProbe: begin
            if (bus.chk_ack) begin
               if (!bus.chk_hit) begin
                  succ_d  = 1'b1;
                  rout_d  = to_q;
                  xout_d  = cx_q;
                  yout_d  = cy_q;
                  kidx_d  = k_q;
                  state_d = StFin;
               end else if (k_q < LastK) begin
                  state_d = StNext;
               end else begin
                  succ_d  = 1'b0;
                  rout_d  = from_q;
                  xout_d  = x_q;
                  yout_d  = y_q;
                  kidx_d  = 3'd0;
                  state_d = StFin;
               end
            end
         end
         StNext: begin
            k_d     = k_q + 3'd1;
            state_d = StCalc;
         end
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         k_q     <= '0;
         from_q  <= '0;
         to_q    <= '0;
         piece_q <= '0;
         x_q     <= '0;
         y_q     <= '0;
         cx_q    <= '0;
         cy_q    <= '0;
         succ_q  <= 1'b0;
         rout_q  <= '0;
         xout_q  <= '0;
         yout_q  <= '0;
         kidx_q  <= '0;
         rsv_q   <= 1'b0;
`ifdef ROT180_EN
         half_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         from_q  <= from_d;
         to_q    <= to_d;
         piece_q <= piece_d;
         x_q     <= x_d;
         y_q     <= y_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         succ_q  <= succ_d;
         rout_q  <= rout_d;
         xout_q  <= xout_d;
         yout_q  <= yout_d;
         kidx_q  <= kidx_d;
         rsv_q   <= rsv_d;
`ifdef ROT180_EN
         half_q  <= half_d;
`endif
      end
   end

   assign bus.chk_req  = (state_q == StProbe);
   assign bus.chk_rot  = to_q;
   assign bus.chk_x    = cx_q;
   assign bus.chk_y    = cy_q;
   assign bus.busy     = (state_q != StIdle);
   assign bus.done     = (state_q == StFin) | rsv_q;
   assign bus.success  = succ_q;
   assign bus.rot_out  = rout_q;
   assign bus.x_out    = xout_q;
   assign bus.y_out    = yout_q;
   assign bus.kick_idx = kidx_q;
endmodule

// File: tb/tb_rotate_kick_engine.sv
// Bench for rotate_kick_engine: directed and random rotations against an SRS table model,
// on a 5-kick and a 1-kick instance sharing one stimulus path.
`timescale 1ns/1ps
module tb_rotate_kick_engine;
   localparam int XW = 5;
   localparam int YW = 6;
`ifdef ROT180_EN
   localparam bit HALF = 1'b1;
`else
   localparam bit HALF = 1'b0;
`endif

   // Offsets [class I/O/JLSTZ][rotation][test], y-up.
   localparam int OX [3][4][5] = '{
      '{'{0,-1,2,-1,2}, '{-1,0,0,0,0}, '{-1,1,-2,1,-2}, '{0,0,0,0,0}},
      '{'{0,0,0,0,0},   '{0,0,0,0,0},  '{0,0,0,0,0},    '{0,0,0,0,0}},
      '{'{0,0,0,0,0},   '{0,1,1,0,1},  '{0,0,0,0,0},    '{0,-1,-1,0,-1}}};
   localparam int OY [3][4][5] = '{
      '{'{0,0,0,0,0}, '{0,0,0,1,-2}, '{1,1,1,0,0}, '{1,1,1,-1,2}},
      '{'{0,0,0,0,0}, '{0,0,0,0,0},  '{0,0,0,0,0}, '{0,0,0,0,0}},
      '{'{0,0,0,0,0}, '{0,0,-1,2,2}, '{0,0,0,0,0}, '{0,0,-1,2,2}}};
   localparam int K180X [5] = '{0, 0, 1, -1, 0};
   localparam int K180Y [5] = '{0, 1, 0, 0, -1};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sel = 1'b0;
   logic start = 1'b0, ack = 1'b0, hit = 1'b0;
   logic [1:0] dir = '0, rot_in = '0;
   logic [2:0] piece = '0;
   logic [XW-1:0] x_in = '0;
   logic [YW-1:0] y_in = '0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rotate_kick_engine_if #(.XW(XW), .YW(YW)) if5 ();
   rotate_kick_engine_if #(.XW(XW), .YW(YW)) if1 ();

   rotate_kick_engine #(.N_KICKS(5), .XW(XW), .YW(YW)) dut5 (.clk(clk), .rst(rst), .bus(if5));
   rotate_kick_engine #(.N_KICKS(1), .XW(XW), .YW(YW)) dut1 (.clk(clk), .rst(rst), .bus(if1));

   assign if5.start = start & ~sel;
   assign if1.start = start & sel;
   assign if5.chk_ack = ack & ~sel;
   assign if1.chk_ack = ack & sel;
   assign if5.chk_hit = hit;
   assign if1.chk_hit = hit;
   assign if5.dir = dir;
   assign if1.dir = dir;
   assign if5.piece = piece;
   assign if1.piece = piece;
   assign if5.rot_in = rot_in;
   assign if1.rot_in = rot_in;
   assign if5.x_in = x_in;
   assign if1.x_in = x_in;
   assign if5.y_in = y_in;
   assign if1.y_in = y_in;

   logic o_req, o_busy, o_done, o_succ;
   logic [1:0] o_crot, o_rout;
   logic [XW-1:0] o_cx, o_xout;
   logic [YW-1:0] o_cy, o_yout;
   logic [2:0] o_kidx;
   assign o_req  = sel ? if1.chk_req  : if5.chk_req;
   assign o_busy = sel ? if1.busy     : if5.busy;
   assign o_done = sel ? if1.done     : if5.done;
   assign o_succ = sel ? if1.success  : if5.success;
   assign o_crot = sel ? if1.chk_rot  : if5.chk_rot;
   assign o_rout = sel ? if1.rot_out  : if5.rot_out;
   assign o_cx   = sel ? if1.chk_x    : if5.chk_x;
   assign o_xout = sel ? if1.x_out    : if5.x_out;
   assign o_cy   = sel ? if1.chk_y    : if5.chk_y;
   assign o_yout = sel ? if1.y_out    : if5.y_out;
   assign o_kidx = sel ? if1.kick_idx : if5.kick_idx;

   // Reference model results.
   bit m_valid, m_succ;
   int m_nq, m_kidx;
   logic [1:0] m_rot [5];
   logic [XW-1:0] m_x [5];
   logic [YW-1:0] m_y [5];
   logic [1:0] m_rout;
   logic [XW-1:0] m_xout;
   logic [YW-1:0] m_yout;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model(input int pc, input int d, input int r, input int x, input int y,
                        input int hitmask, input int nk);
      int cls, to, kx, ky;
      cls = (pc == 0) ? 0 : ((pc == 1 || pc == 7) ? 1 : 2);
      m_valid = (d == 0) || (d == 1) || (d == 2 && HALF);
      to = (d == 0) ? (r + 1) % 4 : ((d == 1) ? (r + 3) % 4 : (r + 2) % 4);
      m_nq = 0;
      m_succ = 1'b0;
      m_rout = 2'(r);
      m_xout = XW'(x);
      m_yout = YW'(y);
      m_kidx = 0;
      if (m_valid) begin
         for (int k = 0; k < nk; k++) begin
            if (d == 2) begin
               kx = K180X[k];
               ky = K180Y[k];
            end else begin
               kx = OX[cls][r][k] - OX[cls][to][k];
               ky = OY[cls][r][k] - OY[cls][to][k];
            end
            m_rot[k] = 2'(to);
            m_x[k] = XW'(x + kx);
            m_y[k] = YW'(y - ky);
            m_nq++;
            if (hitmask[k] == 1'b0) begin
               m_succ = 1'b1;
               m_rout = m_rot[k];
               m_xout = m_x[k];
               m_yout = m_y[k];
               m_kidx = k;
               break;
            end
         end
      end
   endtask

   task automatic run_op(input bit s, input int pc, input int d, input int r, input int x,
                         input int y, input int hitmask, input int dly, input bit stray);
      int q, wcnt, dcyc, lat;
      bit got, abort;
      model(pc, d, r, x, y, hitmask, s ? 1 : 5);
      @(negedge clk);
      sel = s;
      piece = 3'(pc);
      dir = 2'(d);
      rot_in = 2'(r);
      x_in = XW'(x);
      y_in = YW'(y);
      start = 1'b1;
      ack = 1'b0;
      hit = 1'b0;
      q = 0; wcnt = 0; dcyc = 0; got = 1'b0; abort = 1'b0;
      for (int cyc = 1; cyc < 300 && !got && !abort; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         ack = 1'b0;
         hit = 1'b0;
         if (cyc == 1) check("busy_after_start", o_busy, m_valid);
         if (o_done) begin
            got = 1'b1;
            dcyc = cyc;
         end else if (o_req) begin
            check("query_within_budget", q < m_nq, 1);
            if (q >= m_nq) begin
               abort = 1'b1;
            end else begin
               check("chk_rot", o_crot, m_rot[q]);
               check("chk_x", o_cx, m_x[q]);
               check("chk_y", o_cy, m_y[q]);
               if (wcnt >= dly) begin
                  ack = 1'b1;
                  hit = hitmask[q];
                  q++;
                  wcnt = 0;
               end else begin
                  wcnt++;
               end
            end
         end else if (stray) begin
            // Acks without a request and starts while busy must both be ignored.
            ack = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1));
            dir = 2'($urandom_range(0, 3));
            rot_in = 2'($urandom_range(0, 3));
            x_in = XW'($urandom_range(0, 31));
            y_in = YW'($urandom_range(0, 63));
         end
      end
      start = 1'b0;
      ack = 1'b0;
      check("done_seen", got, 1);
      if (got) begin
         lat = m_valid ? 3 + (m_nq - 1) * (dly + 3) + dly : 1;
         check("query_count", q, m_nq);
         check("latency", dcyc, lat);
         check("success", o_succ, m_succ);
         check("rot_out", o_rout, m_rout);
         check("x_out", o_xout, m_xout);
         check("y_out", o_yout, m_yout);
         check("kick_idx", o_kidx, m_kidx);
         @(negedge clk);
         check("done_one_cycle", o_done, 0);
         check("idle_after_done", o_busy, 0);
      end
   endtask

   initial begin
      bit gotd;
      repeat (3) @(negedge clk);
      check("rst_busy", if5.busy, 0);
      check("rst_done", if5.done, 0);
      check("rst_req", if5.chk_req, 0);
      check("rst_success", if5.success, 0);
      check("rst_rot_out", if5.rot_out, 0);
      check("rst_x_out", if5.x_out, 0);
      check("rst_y_out", if5.y_out, 0);
      check("rst_kick_idx", if5.kick_idx, 0);
      check("rst_done_k1", if1.done, 0);
      rst = 1'b0;

      run_op(1'b0, 2, 0, 0, 4, 0, 5'b00000, 1, 1'b0);
      run_op(1'b0, 2, 1, 0, 0, 10, 5'b00011, 1, 1'b0);
      run_op(1'b0, 0, 0, 0, 5, 5, 5'b11111, 1, 1'b0);
      run_op(1'b1, 5, 0, 0, 3, 3, 5'b00001, 1, 1'b0);
      run_op(1'b0, 3, 2, 2, 3, 3, 5'b00000, 1, 1'b0);
      run_op(1'b0, 4, 3, 1, 7, 20, 5'b00000, 1, 1'b0);
      run_op(1'b0, 7, 0, 3, -16, -32, 5'b11110, 2, 1'b0);
      run_op(1'b0, 0, 1, 2, 15, 31, 5'b01111, 1, 1'b1);

      // Reset in the middle of a probe.
      @(negedge clk);
      sel = 1'b0; piece = 3'd2; dir = 2'd0; rot_in = 2'd0; x_in = XW'(4); y_in = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("pre_rst_req", o_req, 1);
      #2 rst = 1'b1;
      #1;
      check("rst_async_req", o_req, 0);
      check("rst_async_done", o_done, 0);
      check("rst_async_busy", o_busy, 0);
      @(negedge clk);
      rst = 1'b0;
      ack = 1'b1;
      hit = 1'b0;
      gotd = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (o_done) gotd = 1'b1;
      end
      ack = 1'b0;
      check("late_ack_no_done", gotd, 0);
      run_op(1'b0, 6, 0, 1, 2, 8, 5'b00111, 1, 1'b0);

      for (int n = 0; n < 40; n++) begin
         run_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 31)) - 16, int'($urandom_range(0, 63)) - 32,
                int'($urandom_range(0, 31)), int'($urandom_range(1, 3)), 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
